// File: rtl/reqack_tph_pkg.sv
// Shared helpers for the two-phase req/ack elastic buffer.
// lvl_w() sizes the occupancy port and the internal token counter.
package reqack_tph_pkg;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/reqack_tph_cdc_sync.sv
// Single-bit synchroniser chain with asynchronous active-low reset.
module reqack_tph_cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reqack_tph_fifo.sv
// Two-phase (toggle) req/ack elastic buffer: DEPTH storage entries plus one
// output register, with optional synchronisers on the incoming toggle of each side.
module reqack_tph_fifo
    import reqack_tph_pkg::*;
#(
    parameter int DWIDTH          = 1,
    parameter int DEPTH           = 4,
    parameter bit INCLUDE_CDC_PRV = 1'b0,
    parameter bit INCLUDE_CDC_NXT = 1'b0,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    output logic                      ack,
    input  logic [DWIDTH-1:0]         i_dat,
    output logic                      req_nxt,
    input  logic                      ack_nxt,
    output logic [DWIDTH-1:0]         o_dat,
    output logic [lvl_w(DEPTH)-1:0]   o_level
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Handshake: a side has a token outstanding while its req level differs
    // from the matching ack level; the receiver toggles ack once to take it.
    logic              req_i;
    logic              ack_nxt_i;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              push;
    logic              launch;

    generate
        if (INCLUDE_CDC_PRV) begin : g_prv_sync
            reqack_tph_cdc_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (req),
                .q     (req_i)
            );
        end else begin : g_prv_direct
            assign req_i = req;
        end

        if (INCLUDE_CDC_NXT) begin : g_nxt_sync
            reqack_tph_cdc_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (ack_nxt),
                .q     (ack_nxt_i)
            );
        end else begin : g_nxt_direct
            assign ack_nxt_i = ack_nxt;
        end
    endgenerate

    assign push   = (req_i != ack) && (count < DEPTH_L);
    assign launch = (req_nxt == ack_nxt_i) && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            req_nxt <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                ack    <= ~ack;
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (launch) begin
                req_nxt <= ~req_nxt;
                rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !launch) begin
                count <= count + LW'(1);
            end else if (launch && !push) begin
                count <= count - LW'(1);
            end
        end
    end

    // Data path carries no reset; it is only meaningful once a token has moved.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_dat;
        end
        if (launch) begin
            o_dat <= mem[rd_ptr];
        end
    end

    assign o_level = count + LW'(req_nxt != ack_nxt_i);

endmodule

// File: tb/tb_reqack_tph_fifo.sv
// Bench for reqack_tph_fifo: three instances (DEPTH=4, DEPTH=3, DEPTH=4 with both synchronisers).
module tb_reqack_tph_fifo;
    import reqack_tph_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req_v;
    logic [2:0]       an_v;
    logic [2:0]       ack_v;
    logic [2:0]       rn_v;
    logic [2:0][7:0]  dat_v;
    logic [2:0][7:0]  odat_v;
    logic [2:0][2:0]  lvl_v;

    int   n_vec = 0;
    int   n_err = 0;
    bit   soak_done;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       req;
        logic [7:0] dat;
        logic       an;
        logic       e_ack;
        logic       e_rn;
        logic [2:0] e_lvl;
        logic       dat_chk;
        logic [7:0] e_dat;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    reqack_tph_fifo #(.DWIDTH(8), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .ack(ack_v[0]), .i_dat(dat_v[0]),
        .req_nxt(rn_v[0]), .ack_nxt(an_v[0]), .o_dat(odat_v[0]), .o_level(lvl_v[0])
    );

    reqack_tph_fifo #(.DWIDTH(8), .DEPTH(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .ack(ack_v[1]), .i_dat(dat_v[1]),
        .req_nxt(rn_v[1]), .ack_nxt(an_v[1]), .o_dat(odat_v[1]), .o_level(lvl_v[1])
    );

    reqack_tph_fifo #(.DWIDTH(8), .DEPTH(4), .INCLUDE_CDC_PRV(1'b1), .INCLUDE_CDC_NXT(1'b1),
                      .SYNC_STAGES(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .ack(ack_v[2]), .i_dat(dat_v[2]),
        .req_nxt(rn_v[2]), .ack_nxt(an_v[2]), .o_dat(odat_v[2]), .o_level(lvl_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [7:0] d, input logic a,
                                input logic ea, input logic ern, input logic [2:0] el,
                                input logic dc, input logic [7:0] ed);
        vec_t v;
        v.req = r; v.dat = d; v.an = a;
        v.e_ack = ea; v.e_rn = ern; v.e_lvl = el; v.dat_chk = dc; v.e_dat = ed;
        tbl.push_back(v);
    endfunction

    // Random producer: toggles req with fresh data, then waits for the matching ack.
    task automatic producer(input int idx, input int n);
        int t;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            d = 8'($urandom_range(0, 255));
            dat_v[idx] = d;
            req_v[idx] = ~req_v[idx];
            exp_q.push_back(d);
            t = 0;
            while (ack_v[idx] != req_v[idx] && t < 400) begin
                tick();
                t++;
            end
            if (t >= 400) begin
                check("soak ack timeout", 32'(ack_v[idx]), 32'(req_v[idx]));
                return;
            end
        end
    endtask

    task automatic consumer(input int idx, input int n);
        int t;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (rn_v[idx] == an_v[idx] && t < 400) begin
                tick();
                t++;
            end
            if (t >= 400) begin
                check("soak req_nxt timeout", 32'(rn_v[idx]), 32'(~an_v[idx]));
                return;
            end
            if (exp_q.size() == 0) begin
                check("soak unexpected token", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("soak data", 32'(odat_v[idx]), 32'(e));
            end
            repeat ($urandom_range(0, 4)) tick();
            an_v[idx] = ~an_v[idx];
        end
    endtask

    // Occupancy model: accepted tokens minus tokens whose ack the buffer has seen,
    // where the buffer sees ack_nxt 'lag' cycles after it is driven.
    task automatic monitor(input int idx, input int lag);
        logic hist[$];
        logic pa;
        logic pn;
        logic ai;
        int   acc = 0;
        int   con = 0;
        pa = ack_v[idx];
        pn = an_v[idx];
        repeat (lag) hist.push_back(an_v[idx]);
        while (!soak_done) begin
            @(posedge clk);
            #2;
            if (ack_v[idx] != pa) begin
                acc++;
                pa = ack_v[idx];
            end
            hist.push_back(an_v[idx]);
            ai = hist.pop_front();
            if (ai != pn) begin
                con++;
                pn = ai;
            end
            check("soak level", 32'(lvl_v[idx]), 32'(acc - con));
        end
    endtask

    task automatic soak(input int idx, input int n, input int lag);
        soak_done = 1'b0;
        exp_q.delete();
        fork
            begin
                fork
                    producer(idx, n);
                    consumer(idx, n);
                join
                soak_done = 1'b1;
            end
            monitor(idx, lag);
        join
        check("soak leftover tokens", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic pa;
        logic pr;
        int   ack_lat;
        int   rn_lat;

        rst_n = 1'b0;
        req_v = '0;
        an_v  = '0;
        dat_v = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset on all instances.
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("reset ack[%0d]", i), 32'(ack_v[i]), 32'd0);
                check($sformatf("reset req_nxt[%0d]", i), 32'(rn_v[i]), 32'd0);
                check($sformatf("reset level[%0d]", i), 32'(lvl_v[i]), 32'd0);
            end
        end

        // Single token, fill/stall/drain, then push+launch in the same cycle at count=2.
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'hA5, 0, 1, 0, 1, 0, 8'h00);
        add(1, 8'hA5, 0, 1, 1, 1, 1, 8'hA5);
        add(1, 8'hA5, 1, 1, 1, 0, 1, 8'hA5);
        add(0, 8'h01, 1, 0, 1, 1, 1, 8'hA5);
        add(1, 8'h02, 1, 1, 0, 2, 1, 8'h01);
        add(0, 8'h03, 1, 0, 0, 3, 1, 8'h01);
        add(1, 8'h04, 1, 1, 0, 4, 1, 8'h01);
        add(0, 8'h05, 1, 0, 0, 5, 1, 8'h01);
        add(1, 8'h06, 1, 0, 0, 5, 1, 8'h01);
        add(1, 8'h06, 1, 0, 0, 5, 1, 8'h01);
        add(1, 8'h06, 0, 0, 1, 4, 1, 8'h02);
        add(1, 8'h06, 0, 1, 1, 5, 1, 8'h02);
        add(1, 8'h06, 1, 1, 0, 4, 1, 8'h03);
        add(1, 8'h06, 0, 1, 1, 3, 1, 8'h04);
        add(1, 8'h06, 1, 1, 0, 2, 1, 8'h05);
        add(1, 8'h06, 0, 1, 1, 1, 1, 8'h06);
        add(1, 8'h06, 1, 1, 1, 0, 1, 8'h06);
        add(1, 8'h06, 1, 1, 1, 0, 1, 8'h06);
        add(0, 8'h11, 1, 0, 1, 1, 1, 8'h06);
        add(1, 8'h22, 1, 1, 0, 2, 1, 8'h11);
        add(0, 8'h33, 1, 0, 0, 3, 1, 8'h11);
        add(1, 8'h44, 0, 1, 1, 3, 1, 8'h22);
        add(1, 8'h44, 0, 1, 1, 3, 1, 8'h22);
        add(1, 8'h44, 1, 1, 0, 2, 1, 8'h33);
        add(1, 8'h44, 0, 1, 1, 1, 1, 8'h44);
        add(1, 8'h44, 1, 1, 1, 0, 1, 8'h44);

        for (int k = 0; k < tbl.size(); k++) begin
            req_v[0] = tbl[k].req;
            dat_v[0] = tbl[k].dat;
            an_v[0]  = tbl[k].an;
            tick();
            check($sformatf("vec%0d ack", k), 32'(ack_v[0]), 32'(tbl[k].e_ack));
            check($sformatf("vec%0d req_nxt", k), 32'(rn_v[0]), 32'(tbl[k].e_rn));
            check($sformatf("vec%0d level", k), 32'(lvl_v[0]), 32'(tbl[k].e_lvl));
            if (tbl[k].dat_chk) begin
                check($sformatf("vec%0d o_dat", k), 32'(odat_v[0]), 32'(tbl[k].e_dat));
            end
        end

        // Synchronised instance: latency through both 3-stage synchronisers.
        pa = ack_v[2];
        pr = rn_v[2];
        ack_lat = 0;
        rn_lat  = 0;
        dat_v[2] = 8'hC3;
        req_v[2] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (ack_v[2] != pa && ack_lat == 0) ack_lat = t;
            if (rn_v[2] != pr && rn_lat == 0) rn_lat = t;
        end
        check("cdc ack latency", 32'(ack_lat), 32'd4);
        check("cdc req_nxt latency", 32'(rn_lat), 32'd5);
        check("cdc o_dat", 32'(odat_v[2]), 32'hC3);
        an_v[2] = 1'b1;
        tick();
        tick();
        check("cdc ack_nxt seen early", 32'(lvl_v[2]), 32'd1);
        tick();
        check("cdc ack_nxt seen", 32'(lvl_v[2]), 32'd0);

        // Reset with three tokens held on instance a.
        req_v[0] = 1'b0; dat_v[0] = 8'h71; tick();
        req_v[0] = 1'b1; dat_v[0] = 8'h72; tick();
        req_v[0] = 1'b0; dat_v[0] = 8'h73; tick();
        check("held level", 32'(lvl_v[0]), 32'd3);
        #3;
        rst_n = 1'b0;
        req_v = '0;
        an_v  = '0;
        #1;
        check("async reset ack", 32'(ack_v[0]), 32'd0);
        check("async reset req_nxt", 32'(rn_v[0]), 32'd0);
        check("async reset level", 32'(lvl_v[0]), 32'd0);
        check("async reset cdc ack", 32'(ack_v[2]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        req_v[0] = 1'b1;
        dat_v[0] = 8'h9E;
        tick();
        check("post-reset ack", 32'(ack_v[0]), 32'd1);
        tick();
        check("post-reset req_nxt", 32'(rn_v[0]), 32'd1);
        check("post-reset o_dat", 32'(odat_v[0]), 32'h9E);
        an_v[0] = 1'b1;
        tick();
        check("post-reset level", 32'(lvl_v[0]), 32'd0);

        // Random soaks: non-pow2 depth, base depth, synchronised instance.
        soak(1, 1000, 0);
        soak(0, 300, 0);
        soak(2, 300, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
